// File: rtl/serial_sub_flags.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_flags
//  Description : Bit-serial, LSB-first N-bit subtractor with borrow-in.
//                Computes diff = a - b - bin over N clock cycles under a
//                start/busy/done handshake. Produces negative, zero,
//                overflow and borrow-out flags plus a magnitude output.
//                Signed/unsigned interpretation is selected per operation.
//
//  Ports       : clk           - rising-edge clock
//                rst_n         - asynchronous active-low reset
//                start         - operation request, accepted when ready=1
//                a, b          - minuend / subtrahend (captured on start)
//                bin           - borrow-in (captured on start)
//                mode          - 1 = signed, 0 = unsigned (captured on start)
//                ready         - high in IDLE or DONE
//                busy          - high while bits are being processed
//                done          - one-cycle pulse when the result is valid
//                diff          - a - b - bin modulo 2^N
//                magnitude     - |diff| when signed, diff when unsigned
//                borrow_out    - borrow out of bit N-1
//                negative_flag - diff[N-1]
//                zero_flag     - diff == 0
//                overflow_flag - signed overflow (mode=1) or borrow (mode=0)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_flags #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         mode,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic [N-1:0] magnitude,
    output logic         borrow_out,
    output logic         negative_flag,
    output logic         zero_flag,
    output logic         overflow_flag
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_DONE = 2'd2;

    // Exit condition from RUN: the counter compares against N-1 directly, so
    // any slack values above N-1 in a wider counter are never reached.
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    // Operand shift registers: bit 0 always holds the bit being processed.
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    // Operand sign bits kept aside, since the shift registers lose them.
    logic          r_a_msb;
    logic          r_b_msb;
    logic          r_mode;
    logic          r_borrow;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_shift;

    // Registered result and flags, updated only on entry to DONE.
    logic [N-1:0]  r_diff;
    logic [N-1:0]  r_magnitude;
    logic          r_borrow_out;
    logic          r_negative;
    logic          r_zero;
    logic          r_overflow;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic          w_accept;
    logic          w_last;
    logic          w_bit_a;
    logic          w_bit_b;
    logic          w_bit_d;
    logic          w_borrow_nxt;
    logic [N-1:0]  w_result;
    logic          w_neg;
    logic          w_zero;
    logic          w_signed_ovf;
    logic          w_ovf;
    logic [N-1:0]  w_mag;

    // start is only honoured in IDLE or DONE; anything during RUN is ignored.
    assign w_accept     = start && (r_state != c_RUN);
    assign w_last       = (r_count == c_LAST);

    assign w_bit_a      = r_a[0];
    assign w_bit_b      = r_b[0];
    assign w_bit_d      = w_bit_a ^ w_bit_b ^ r_borrow;
    assign w_borrow_nxt = (~w_bit_a & w_bit_b) | (~(w_bit_a ^ w_bit_b) & r_borrow);

    // New bit enters from the MSB end; after N shifts bit i sits at position i.
    // On the final bit this is the complete difference.
    assign w_result     = {w_bit_d, r_shift[N-1:1]};

    assign w_neg        = w_result[N-1];
    assign w_zero       = (w_result == '0);
    // Operands of differing sign whose result sign differs from the minuend.
    assign w_signed_ovf = (r_a_msb ^ r_b_msb) & (w_result[N-1] ^ r_a_msb);
    assign w_ovf        = r_mode ? w_signed_ovf : w_borrow_nxt;
    // Two's-complement negate; the most negative value maps onto itself.
    assign w_mag        = (r_mode && w_neg) ? ((~w_result) + N'(1)) : w_result;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                // Back-to-back: a start in the DONE cycle goes straight to RUN.
                w_state_nxt = start ? c_RUN : c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Operand capture and serial processing
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_mode   <= 1'b0;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_shift  <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_a_msb  <= a[N-1];
            r_b_msb  <= b[N-1];
            r_mode   <= mode;
            r_borrow <= bin;
            r_count  <= '0;
            r_shift  <= '0;
        end else if (r_state == c_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_borrow <= w_borrow_nxt;
            r_shift  <= w_result;
            r_count  <= w_last ? '0 : (r_count + CW'(1));
        end
    end

    // ------------------------------------------------------------------------
    // Result and flag registers: loaded once per operation on the last bit,
    // so they hold through any following RUN and are not touched by start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff       <= '0;
            r_magnitude  <= '0;
            r_borrow_out <= 1'b0;
            r_negative   <= 1'b0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
        end else if ((r_state == c_RUN) && w_last) begin
            r_diff       <= w_result;
            r_magnitude  <= w_mag;
            r_borrow_out <= w_borrow_nxt;
            r_negative   <= w_neg;
            r_zero       <= w_zero;
            r_overflow   <= w_ovf;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready         = (r_state != c_RUN);
    assign busy          = (r_state == c_RUN);
    assign done          = (r_state == c_DONE);
    assign diff          = r_diff;
    assign magnitude     = r_magnitude;
    assign borrow_out    = r_borrow_out;
    assign negative_flag = r_negative;
    assign zero_flag     = r_zero;
    assign overflow_flag = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_flags.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub_flags
//  Description : Self-checking bench for serial_sub_flags. Directed vector
//                table, hand-written handshake/reset sequences and random
//                operations checked against an arithmetic reference model.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_flags;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int M  = 1 << N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         mode;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic [N-1:0] magnitude;
    logic         borrow_out;
    logic         negative_flag;
    logic         zero_flag;
    logic         overflow_flag;

    int n_cmp = 0;
    int n_bad = 0;

    serial_sub_flags #(.N(N), .CW(CW)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .bin           (bin),
        .mode          (mode),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .diff          (diff),
        .magnitude     (magnitude),
        .borrow_out    (borrow_out),
        .negative_flag (negative_flag),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic         mode;
        logic [N-1:0] diff;
        logic [N-1:0] mag;
        logic         bo;
        logic         neg;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t tbl [0:8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic vec_t model(input logic [N-1:0] a_i, input logic [N-1:0] b_i,
                                   input logic bin_i, input logic mode_i);
        vec_t        v;
        int          ua, ub, full, sa, sb, sres;
        logic [31:0] fw;
        ua   = int'(a_i);
        ub   = int'(b_i);
        full = ua - ub - int'(bin_i);
        fw   = full;
        sa   = a_i[N-1] ? ua - M : ua;
        sb   = b_i[N-1] ? ub - M : ub;
        sres = sa - sb - int'(bin_i);
        v.a    = a_i;
        v.b    = b_i;
        v.bin  = bin_i;
        v.mode = mode_i;
        v.diff = fw[N-1:0];
        v.bo   = (full < 0);
        v.neg  = v.diff[N-1];
        v.zero = (v.diff == '0);
        v.mag  = (mode_i && v.neg) ? N'((M - int'(v.diff)) % M) : v.diff;
        v.ovf  = mode_i ? ((sres < -(M / 2)) || (sres > (M / 2) - 1)) : v.bo;
        return v;
    endfunction

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
        chk({tag, "_mag"},  32'(magnitude), 32'(e.mag));
        chk({tag, "_bo"},   32'(borrow_out), 32'(e.bo));
        chk({tag, "_neg"},  32'(negative_flag), 32'(e.neg));
        chk({tag, "_zero"}, 32'(zero_flag), 32'(e.zero));
        chk({tag, "_ovf"},  32'(overflow_flag), 32'(e.ovf));
    endtask

    // Presents an operation and returns #1 after the accepting edge.
    task automatic start_op(input logic [N-1:0] a_i, input logic [N-1:0] b_i,
                            input logic bin_i, input logic mode_i);
        @(negedge clk);
        a     = a_i;
        b     = b_i;
        bin   = bin_i;
        mode  = mode_i;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat = edges elapsed since the call.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 4 * N) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_op(input logic [N-1:0] a_i, input logic [N-1:0] b_i,
                          input logic bin_i, input logic mode_i, output int lat);
        start_op(a_i, b_i, bin_i, mode_i);
        wait_done(lat);
    endtask

    initial begin
        int   lat;
        vec_t e;
        logic [N-1:0] held;

        tbl[0] = '{8'd10,  8'd3,   1'b0, 1'b0, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'd3,   8'd10,  1'b0, 1'b0, 8'hF9, 8'hF9, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h80,  8'h01,  1'b0, 1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'd3,   8'd10,  1'b0, 1'b1, 8'hF9, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'd5,   8'd4,   1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'd0,   8'd0,   1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h80,  8'h00,  1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h80,  8'h00,  1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8'h00,  8'h80,  1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        mode  = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        e = '0;
        check_all("rst", e);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            start_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].mode);
            chk($sformatf("v%0d_busy", i),  32'(busy),  32'd1);
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'd0);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(N));
            check_all($sformatf("v%0d", i), tbl[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done),  32'd0);
            chk($sformatf("v%0d_idle_ready", i), 32'(ready), 32'd1);
            // Results hold after DONE
            check_all($sformatf("v%0d_hold", i), tbl[i]);
        end

        // start pulsed mid-RUN with different operands is ignored
        start_op(8'd10, 8'd3, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a     = 8'd100;
        b     = 8'd1;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("midrun_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check_all("midrun", tbl[0]);
        @(posedge clk);
        #1;
        chk("midrun_no_restart", 32'(busy), 32'd0);

        // Back-to-back: start asserted in the DONE cycle
        run_op(8'd3, 8'd10, 1'b0, 1'b1, lat);
        check_all("b2b_first", tbl[3]);
        a     = 8'd20;
        b     = 8'd5;
        bin   = 1'b0;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy_no_gap", 32'(busy), 32'd1);
        chk("b2b_done_low",    32'(done), 32'd0);
        check_all("b2b_hold_during_run", tbl[3]);
        wait_done(lat);
        chk("b2b_latency", 32'(lat), 32'(N));
        check_all("b2b_second", model(8'd20, 8'd5, 1'b0, 1'b0));

        // Reset mid-RUN at bit 4: previous result is non-zero (diff = 15)
        held = diff;
        chk("pre_reset_nonzero", 32'(held != '0), 32'd1);
        start_op(8'd200, 8'd7, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_done",  32'(done),  32'd0);
        e = '0;
        check_all("arst", e);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst_hold_done%0d", k), 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("arst_no_done%0d", k), 32'(done), 32'd0);
        end
        run_op(8'd20, 8'd5, 1'b0, 1'b0, lat);
        chk("post_reset_diff", 32'(diff), 32'd15);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [N-1:0] ra, rb;
            logic         rbin, rmode;
            ra    = N'($urandom);
            rb    = N'($urandom);
            rbin  = 1'($urandom);
            rmode = 1'($urandom);
            run_op(ra, rb, rbin, rmode, lat);
            chk($sformatf("r%0d_latency", i), 32'(lat), 32'(N));
            check_all($sformatf("r%0d", i), model(ra, rb, rbin, rmode));
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
